// File: rtl/jtag_cmd_sequencer.sv
// Byte-stream command sequencer: decodes Ping/Write/Read host commands, issues
// single-word SDRAM requests and returns one- or two-byte responses to the host.
module jtag_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        start_write,
    output logic        start_read,
    output logic [24:0] address,
    output logic [15:0] write_data,
    input  logic [15:0] read_data,
    input  logic        operation_done,
    input  logic        busy,
    output logic        handshake_done,
    output logic [7:0]  last_cmd,
    output logic [7:0]  err_count,
    output logic [3:0]  state_dbg
);
    localparam logic [7:0] OP_PING  = 8'h50;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK = 8'h41;
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h3F;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        GET_ADDR  = 4'd1,
        GET_DATA  = 4'd2,
        ISSUE_WR  = 4'd3,
        WAIT_WR   = 4'd4,
        ISSUE_RD  = 4'd5,
        WAIT_RD   = 4'd6,
        LOAD_RESP = 4'd7,
        ERR_RESP  = 4'd8,
        SEND      = 4'd9
    } state_t;

    state_t state, state_next;

    logic [31:0]   addr_shift;
    logic [15:0]   data_shift;
    logic [1:0]    byte_cnt;
    logic [CW-1:0] idle_cnt;
    logic [7:0]    resp_hi;
    logic [7:0]    resp_lo;
    logic          resp_two;
    logic          resp_idx;
    logic          rx_fire;
    logic          tx_fire;
    logic          collecting;
    logic          timed_out;
    logic          last_addr_byte;
    logic          last_data_byte;
    logic          unknown_op;
    logic          err_inc;

    // rx_ready is held low while reset is asserted so the port shows its reset value
    assign collecting     = (state == GET_ADDR) || (state == GET_DATA);
    assign rx_ready       = !reset && ((state == IDLE) || collecting);
    assign rx_fire        = rx_valid && rx_ready;
    assign tx_valid       = (state == SEND);
    assign tx_fire        = tx_valid && tx_ready;
    assign tx_byte        = resp_idx ? resp_lo : resp_hi;
    assign start_write    = (state == ISSUE_WR) && !busy;
    assign start_read     = (state == ISSUE_RD) && !busy;
    assign address        = addr_shift[24:0];
    assign write_data     = data_shift;
    assign state_dbg      = state;
    assign timed_out      = collecting && !rx_fire && (idle_cnt == TIMEOUT_LAST);
    assign last_addr_byte = (state == GET_ADDR) && rx_fire && (byte_cnt == 2'd3);
    assign last_data_byte = (state == GET_DATA) && rx_fire && (byte_cnt == 2'd1);
    assign unknown_op     = (state == IDLE) && rx_fire && (rx_byte != OP_PING) &&
                            (rx_byte != OP_WRITE) && (rx_byte != OP_READ);
    assign err_inc        = unknown_op || timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_byte == OP_PING)
                        state_next = LOAD_RESP;
                    else if ((rx_byte == OP_WRITE) || (rx_byte == OP_READ))
                        state_next = GET_ADDR;
                    else
                        state_next = ERR_RESP;
                end
            end
            GET_ADDR: begin
                if (timed_out)
                    state_next = IDLE;
                else if (last_addr_byte)
                    state_next = (last_cmd == OP_WRITE) ? GET_DATA : ISSUE_RD;
            end
            GET_DATA: begin
                if (timed_out)           state_next = IDLE;
                else if (last_data_byte) state_next = ISSUE_WR;
            end
            ISSUE_WR:  if (!busy) state_next = WAIT_WR;
            WAIT_WR:   if (operation_done) state_next = SEND;
            ISSUE_RD:  if (!busy) state_next = WAIT_RD;
            WAIT_RD:   if (operation_done) state_next = SEND;
            LOAD_RESP: state_next = SEND;
            ERR_RESP:  state_next = SEND;
            SEND: begin
                if (tx_fire && !(resp_two && !resp_idx))
                    state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // Payload assembly, inter-byte timeout and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_shift     <= '0;
            data_shift     <= '0;
            byte_cnt       <= '0;
            idle_cnt       <= '0;
            last_cmd       <= '0;
            err_count      <= '0;
            handshake_done <= 1'b0;
        end else begin
            if ((state == IDLE) && rx_fire) begin
                last_cmd <= rx_byte;
                byte_cnt <= '0;
                if (rx_byte == OP_PING)
                    handshake_done <= 1'b1;
            end
            if (collecting) begin
                if (rx_fire) begin
                    idle_cnt <= '0;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (state == GET_ADDR) addr_shift <= {addr_shift[23:0], rx_byte};
                    else                   data_shift <= {data_shift[7:0], rx_byte};
                end else if (timed_out) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
            if (err_inc && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    // Response buffer; single-byte responses live in resp_hi
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_hi  <= '0;
            resp_lo  <= '0;
            resp_two <= 1'b0;
            resp_idx <= 1'b0;
        end else begin
            case (state)
                LOAD_RESP: begin resp_hi <= RESP_ACK; resp_two <= 1'b0; resp_idx <= 1'b0; end
                ERR_RESP:  begin resp_hi <= RESP_ERR; resp_two <= 1'b0; resp_idx <= 1'b0; end
                WAIT_WR: begin
                    if (operation_done) begin
                        resp_hi  <= RESP_OK;
                        resp_two <= 1'b0;
                        resp_idx <= 1'b0;
                    end
                end
                WAIT_RD: begin
                    if (operation_done) begin
                        resp_hi  <= read_data[15:8];
                        resp_lo  <= read_data[7:0];
                        resp_two <= 1'b1;
                        resp_idx <= 1'b0;
                    end
                end
                SEND: begin
                    if (tx_fire)
                        resp_idx <= resp_two && !resp_idx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Bench for jtag_cmd_sequencer: command-level model with response/request
// scoreboards, an SDRAM responder and directed command sequences.
module tb_jtag_cmd_sequencer;
    localparam int TO = 100;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        start_write;
    logic        start_read;
    logic [24:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        operation_done;
    logic        busy;
    logic        handshake_done;
    logic [7:0]  last_cmd;
    logic [7:0]  err_count;
    logic [3:0]  state_dbg;

    logic        sd_busy;
    logic        hold_busy;
    int          sd_lat;

    int total = 0;
    int bad   = 0;

    jtag_cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .start_write(start_write), .start_read(start_read),
        .address(address), .write_data(write_data), .read_data(read_data),
        .operation_done(operation_done), .busy(busy),
        .handshake_done(handshake_done), .last_cmd(last_cmd),
        .err_count(err_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    assign busy = sd_busy | hold_busy;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("[TB] FAIL %s: got 0x%0h, nothing expected", name, act);
    endtask

    // Command-level model: expected responses, SDRAM requests and status
    logic [7:0]  exp_tx[$];
    bit          exp_op_rd[$];
    logic [24:0] exp_op_addr[$];
    logic [15:0] exp_op_data[$];
    logic [15:0] exp_mem [logic [24:0]];
    int          model_err  = 0;
    logic [7:0]  model_last = 8'h00;
    bit          model_hs   = 1'b0;
    logic [7:0]  tx_log[$];

    task automatic model_cmd(input byte_q_t c);
        logic [31:0] a32;
        logic [24:0] a;
        logic [15:0] d;
        model_last = c[0];
        if (c[0] == 8'h50) begin
            exp_tx.push_back(8'h41);
            model_hs = 1'b1;
        end else if (c[0] == 8'h57 || c[0] == 8'h52) begin
            a32 = (32'(c[1]) << 24) + (32'(c[2]) << 16) + (32'(c[3]) << 8) + 32'(c[4]);
            a   = 25'(a32 % (32'd1 << 25));
            exp_op_rd.push_back(c[0] == 8'h52);
            exp_op_addr.push_back(a);
            if (c[0] == 8'h57) begin
                d = 16'(c[5]) * 16'd256 + 16'(c[6]);
                exp_op_data.push_back(d);
                exp_mem[a] = d;
                exp_tx.push_back(8'h4B);
            end else begin
                d = exp_mem.exists(a) ? exp_mem[a] : 16'hDEAD;
                exp_op_data.push_back(16'h0000);
                exp_tx.push_back(8'(d / 16'd256));
                exp_tx.push_back(8'(d % 16'd256));
            end
        end else begin
            exp_tx.push_back(8'h3F);
            if (model_err < 255) model_err++;
        end
    endtask

    // SDRAM responder: one access at a time, completes sd_lat cycles after the request
    logic [15:0] sd_mem [logic [24:0]];
    bit          sd_wr;
    logic [24:0] sd_a;
    logic [15:0] sd_d;
    initial begin
        operation_done = 1'b0;
        sd_busy        = 1'b0;
        read_data      = 16'h0000;
        forever begin
            @(negedge clk);
            if (!reset && (start_write || start_read)) begin
                sd_wr = start_write;
                sd_a  = address;
                sd_d  = write_data;
                @(posedge clk); #1;
                sd_busy = 1'b1;
                repeat (sd_lat) @(posedge clk);
                #1;
                if (sd_wr) sd_mem[sd_a] = sd_d;
                read_data      = sd_wr ? 16'h0000 : (sd_mem.exists(sd_a) ? sd_mem[sd_a] : 16'hDEAD);
                operation_done = 1'b1;
                sd_busy        = 1'b0;
                @(posedge clk); #1;
                operation_done = 1'b0;
                read_data      = 16'h0000;
            end
        end
    end

    // Every-cycle compare against the model queues and the handshake rules
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_byte;
    bit          outstanding = 1'b0;
    bit          expect_tx = 1'b0;
    logic [24:0] out_addr;
    logic [15:0] out_data;
    bit          op_rd;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold   = 1'b0;
            outstanding = 1'b0;
            expect_tx   = 1'b0;
        end else begin
            if (expect_tx) check_output("done_to_tx", tx_valid, 1);
            expect_tx = 1'b0;
            if (prev_hold) begin
                check_output("tx_hold_valid", tx_valid, 1);
                check_output("tx_hold_byte", tx_byte, prev_byte);
            end
            if (tx_valid) check_output("rx_blocked", rx_ready, 0);
            if (start_write || start_read) begin
                check_output("start_busy", busy, 0);
                if (exp_op_rd.size() == 0) begin
                    fail_now("unexpected_start", address);
                end else begin
                    op_rd = exp_op_rd.pop_front();
                    check_output("start_kind", {start_read, start_write}, op_rd ? 2'b10 : 2'b01);
                    check_output("start_addr", address, exp_op_addr.pop_front());
                    if (op_rd) void'(exp_op_data.pop_front());
                    else       check_output("start_data", write_data, exp_op_data.pop_front());
                end
                outstanding = 1'b1;
                out_addr    = address;
                out_data    = write_data;
            end else if (outstanding) begin
                check_output("addr_stable", address, out_addr);
                check_output("data_stable", write_data, out_data);
                if (operation_done) begin
                    outstanding = 1'b0;
                    expect_tx   = 1'b1;
                end
            end
            if (tx_valid && tx_ready) begin
                tx_log.push_back(tx_byte);
                if (exp_tx.size() == 0) fail_now("unexpected_tx", tx_byte);
                else                    check_output("tx_byte", tx_byte, exp_tx.pop_front());
            end
            prev_hold = tx_valid && !tx_ready;
            prev_byte = tx_byte;
        end
    end

    task automatic apply_stimulus(input logic [7:0] b);
        int n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) fail_now("rx_accept_timeout", b);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input byte_q_t c);
        model_cmd(c);
        foreach (c[i]) apply_stimulus(c[i]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (!(exp_tx.size() == 0 && exp_op_rd.size() == 0 && state_dbg == 4'd0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) fail_now(name, state_dbg);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check_output({tag, "_rx_ready"}, rx_ready, 0);
        check_output({tag, "_tx_valid"}, tx_valid, 0);
        check_output({tag, "_starts"}, {start_write, start_read}, 0);
        check_output({tag, "_hs"}, handshake_done, 0);
        check_output({tag, "_tx_byte"}, tx_byte, 0);
        check_output({tag, "_last_cmd"}, last_cmd, 0);
        check_output({tag, "_err"}, err_count, 0);
        check_output({tag, "_state"}, state_dbg, 0);
        check_output({tag, "_addr"}, address, 0);
        check_output({tag, "_wdata"}, write_data, 0);
    endtask

    initial begin
        #500000;
        fail_now("watchdog", state_dbg);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        tx_ready  = 1'b1;
        hold_busy = 1'b0;
        sd_lat    = 4;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("rx_ready_after_reset", rx_ready, 1);
        @(posedge clk); #1;

        // Ping: response two cycles after the opcode
        send_cmd('{8'h50});
        @(negedge clk);
        check_output("ping_n1_valid", tx_valid, 0);
        @(negedge clk);
        check_output("ping_n2_valid", tx_valid, 1);
        check_output("ping_byte", tx_byte, 8'h41);
        check_output("ping_hs", handshake_done, 1);
        check_output("ping_last", last_cmd, 8'h50);
        @(posedge clk); #1;
        wait_drain("ping_drain");

        // Write then read back the same word
        send_cmd('{8'h57, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h42});
        @(negedge clk);
        check_output("wr_start", start_write, 1);
        check_output("wr_addr", address, 25'h0100000);
        check_output("wr_data", write_data, 16'h0042);
        @(posedge clk); #1;
        wait_drain("wr_drain");
        check_output("wr_resp", tx_log[tx_log.size()-1], 8'h4B);

        send_cmd('{8'h52, 8'h00, 8'h10, 8'h00, 8'h00});
        @(negedge clk);
        check_output("rd_start", start_read, 1);
        check_output("rd_addr", address, 25'h0100000);
        @(posedge clk); #1;
        wait_drain("rd_drain");
        check_output("rd_hi", tx_log[tx_log.size()-2], 8'h00);
        check_output("rd_lo", tx_log[tx_log.size()-1], 8'h42);
        @(negedge clk);
        check_output("rd_rx_ready", rx_ready, 1);
        @(posedge clk); #1;

        // Upper address bits are dropped; read response stalled between bytes
        send_cmd('{8'h57, 8'hFF, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD});
        wait_drain("wr2_drain");
        tx_ready = 1'b0;
        send_cmd('{8'h52, 8'h01, 8'h12, 8'h34, 8'h56});
        @(negedge clk);
        check_output("rd2_addr", address, 25'h1123456);
        n = 0;
        while (!tx_valid && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_drain("rd2_drain");
        check_output("rd2_hi", tx_log[tx_log.size()-2], 8'hAB);
        check_output("rd2_lo", tx_log[tx_log.size()-1], 8'hCD);

        // Unknown opcode under backpressure
        tx_ready = 1'b0;
        send_cmd('{8'h13});
        n = 0;
        while (!tx_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("unk_valid", tx_valid, 1);
            check_output("unk_byte", tx_byte, 8'h3F);
        end
        check_output("unk_err", err_count, 1);
        check_output("unk_last", last_cmd, 8'h13);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_drain("unk_drain");

        // Inter-byte timeout
        model_last = 8'h57;
        apply_stimulus(8'h57);
        apply_stimulus(8'h00);
        n = 0;
        forever begin
            @(negedge clk);
            if (state_dbg == 4'd0 || n >= 300) break;
            n++;
        end
        check_output("timeout_cycles", n, TO);
        model_err++;
        check_output("timeout_err", err_count, model_err);
        check_output("timeout_last", last_cmd, model_last);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;

        // Busy holds off the start pulse; reset while waiting aborts the access
        sd_lat    = 30;
        hold_busy = 1'b1;
        send_cmd('{8'h57, 8'h00, 8'h00, 8'h00, 8'h07, 8'hBE, 8'hEF});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("busy_no_start", start_write, 0);
            check_output("busy_state", state_dbg, 3);
        end
        @(posedge clk); #1;
        hold_busy = 1'b0;
        @(negedge clk);
        check_output("busy_release_start", start_write, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("wait_wr_state", state_dbg, 4);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_tx.delete();
        exp_mem.delete(25'h0000007);
        model_err  = 0;
        model_last = 8'h00;
        model_hs   = 1'b0;
        check_reset_values("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        check_output("post_abort_valid", tx_valid, 0);
        check_output("post_abort_state", state_dbg, 0);
        check_output("post_abort_err", err_count, model_err);
        check_output("post_abort_hs", handshake_done, model_hs);
        @(posedge clk); #1;

        sd_lat = 4;
        send_cmd('{8'h50});
        wait_drain("final_drain");
        check_output("final_hs", handshake_done, model_hs);
        check_output("final_last", last_cmd, model_last);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtag_cmd_sequencer.md
# jtag_cmd_sequencer

Byte-level command sequencer between the JTAG byte channel and `sdram_interface`. It parses host commands arriving one byte at a time, assembles address and data fields, and issues single-word write or read requests on the `start_write`/`start_read` handshake. It returns one- or two-byte responses to the host. It replaces the fixed test sequence in the top level, so the PC drives SDRAM accesses directly.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: maximum idle cycles allowed between payload bytes before the command is aborted (about 1 s at 50 MHz).
- `clk` in 1: system clock. Rising edge only.
- `reset` in 1: asynchronous, active-high reset.
- `rx_byte` in 8: host byte.
- `rx_valid` in 1: `rx_byte` is valid.
- `rx_ready` out 1: the block can accept a byte. A byte transfers on `rx_valid && rx_ready`.
- `tx_byte` out 8: response byte.
- `tx_valid` out 1: `tx_byte` is valid. It holds until accepted.
- `tx_ready` in 1: the host side accepts the byte. A byte transfers on `tx_valid && tx_ready`.
- `start_write` out 1: one-cycle write request to `sdram_interface`.
- `start_read` out 1: one-cycle read request to `sdram_interface`.
- `address` out 25: word address. It is stable from the start pulse until `operation_done`.
- `write_data` out 16: write word. It is stable from the start pulse until `operation_done`.
- `read_data` in 16: read word. It is valid in the cycle `operation_done` is high.
- `operation_done` in 1: one-cycle completion pulse.
- `busy` in 1: `sdram_interface` is executing an operation.
- `handshake_done` out 1: sticky. Set by the first valid Ping.
- `last_cmd` out 8: opcode byte of the most recent command accepted in IDLE.
- `err_count` out 8: saturating count of unknown opcodes plus timeouts.
- `state_dbg` out 4: current state encoding, used for LEDs.

## Operation
- Opcodes are the first byte received in IDLE:
  - 0x50 'P' (Ping): no payload. Response is 0x41 'A'. Sets `handshake_done`.
  - 0x57 'W' (Write): payload is 4 address bytes, MSB first, then 2 data bytes, MSB first. Response is 0x4B 'K' after `operation_done`.
  - 0x52 'R' (Read): payload is 4 address bytes, MSB first. Response is `read_data[15:8]` then `read_data[7:0]`.
  - Any other opcode: response is 0x3F '?'. `err_count` increments.
- Address assembly: a 32-bit shift register, with `address` = bits [24:0]. Bits [31:25] are discarded without error.
- States, with `state_dbg` encoding:
  - IDLE (0): `rx_ready`=1. An accepted byte is decoded as an opcode and latched into `last_cmd`. Next state is GET_ADDR, LOAD_RESP or ERR_RESP.
  - GET_ADDR (1): `rx_ready`=1. Collects 4 bytes, then goes to GET_DATA (W) or ISSUE_RD (R).
  - GET_DATA (2): `rx_ready`=1. Collects 2 bytes, then goes to ISSUE_WR.
  - ISSUE_WR (3): `rx_ready`=0. Waits for `busy`=0, pulses `start_write`, then goes to WAIT_WR.
  - WAIT_WR (4): on `operation_done`, loads 'K' and goes to SEND.
  - ISSUE_RD (5): `rx_ready`=0. Waits for `busy`=0, pulses `start_read`, then goes to WAIT_RD.
  - WAIT_RD (6): on `operation_done`, latches `read_data` and goes to SEND with 2 response bytes.
  - LOAD_RESP (7) / ERR_RESP (8): loads 'A' or '?' (1 byte) and goes to SEND.
  - SEND (9): presents the buffered bytes in order. Returns to IDLE after the last byte is accepted.
- `rx_ready`=0 in all states except IDLE, GET_ADDR and GET_DATA. No bytes are accepted while a response is pending.
- Timeout: a counter clears on every accepted byte and counts each cycle spent in GET_ADDR or GET_DATA. When it reaches TIMEOUT_CYCLES-1, the command aborts and the block returns to IDLE. There is no response and `err_count` increments.
- `operation_done` outside WAIT_WR and WAIT_RD is ignored.
- `err_count` saturates at 0xFF.

## Timing
- Reset values:
  - `rx_ready`, `tx_valid`, `start_write`, `start_read`, `handshake_done` = 0.
  - `tx_byte`, `last_cmd`, `err_count`, `state_dbg` = 0.
  - `address`, `write_data` = 0.
  - Assertion of `reset` mid-operation discards any partial command and the response buffer. A later `operation_done` from the aborted access is ignored.
- `rx_ready` goes to 1 in the first cycle after reset deassertion.
- Last payload byte accepted in cycle N: the block is in ISSUE_* in cycle N+1. The start pulse is in cycle N+1 if `busy`=0, otherwise in the first cycle after `busy` falls.
- Start pulses are exactly 1 cycle wide. At most one outstanding SDRAM operation.
- `operation_done` in cycle M: `tx_valid`=1 with the first response byte in cycle M+1.
- Opcode accepted in cycle N: for P and unknown opcodes, `tx_valid`=1 in cycle N+2.
- On a 2-byte response, byte 2 appears the cycle after byte 1 is accepted. `tx_valid` stays high between the two bytes if no stall occurs.
- `tx_byte` and `tx_valid` are stable while `tx_ready`=0.

## Test plan
- Ping: reset, send 0x50 -> `tx_byte`=0x41 with `handshake_done`=1; `last_cmd`=0x50.
- Write: send 57 00 10 00 00 00 42 -> one `start_write` pulse with `address`=0x100000 and `write_data`=0x0042; after `operation_done`, `tx_byte`=0x4B.
- Read-back: send 52 00 10 00 00 with the model returning 0x0042 -> one `start_read` pulse with `address`=0x100000; then bytes 0x00, 0x42; then `rx_ready`=1.
- Unknown and backpressure: send 0x13 with `tx_ready` held low 10 cycles -> `tx_byte`=0x3F held stable for all 10 cycles; `err_count`=1.
- Timeout: with TIMEOUT_CYCLES=100, send 57 00 then stall -> return to IDLE after 100 idle cycles; `err_count` increments; no `start_write` and no response.
- Busy and reset: `busy`=1 during ISSUE_WR -> no pulse until `busy` falls. Then assert `reset` in WAIT_WR -> all outputs return to their reset values, and a later `operation_done` produces no response.
